// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU class/opcode encodings and sequencer states
package alu_pkg;

  // Operation class (fnclass) encodings
  localparam logic [1:0] SHIFT = 2'b00;
  localparam logic [1:0] RSVD  = 2'b01;
  localparam logic [1:0] ARITH = 2'b10;
  localparam logic [1:0] LOGIC = 2'b11;

  // Opcode encodings within a class
  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b11;
  localparam logic [1:0] AND = 2'b00;
  localparam logic [1:0] SHL = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

endpackage

// File: rtl/ALU.sv
// rtl/ALU.sv - combinational ALU: shift, arithmetic and logic classes with flags
module ALU
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [1:0]   opcode,
  input  logic [1:0]   fnclass,
  output logic [N-1:0] out,
  output logic         zerof,
  output logic         ovf,
  output logic         c_out
);

  localparam int SW = $clog2(N);

  logic [N:0]    sum;
  logic [N-1:0]  b_eff;
  logic [SW-1:0] sh;

  // Result and flags; subtract is a + ~b + 1, so c_out means "no borrow"
  always_comb begin
    out   = '0;
    ovf   = 1'b0;
    c_out = 1'b0;
    sum   = '0;
    b_eff = b;
    sh    = b[SW-1:0];
    case (fnclass)
      ARITH: begin
        b_eff = (opcode == SUB) ? ~b : b;
        sum   = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, (opcode == SUB)};
        out   = sum[N-1:0];
        c_out = sum[N];
        ovf   = (a[N-1] == b_eff[N-1]) && (out[N-1] != a[N-1]);
      end
      LOGIC: begin
        case (opcode)
          2'b00:   out = a & b;
          2'b01:   out = a | b;
          2'b10:   out = a ^ b;
          default: out = ~(a | b);
        endcase
      end
      SHIFT: begin
        case (opcode)
          2'b00:   out = a >> sh;
          2'b01:   out = a << sh;
          2'b10:   out = $unsigned($signed(a) >>> sh);
          default: out = (a << sh) | (a >> (N - int'(sh)));
        endcase
      end
      default: out = '0;
    endcase
    zerof = (out == '0);
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - valid/ready command/response wrapper around ALU
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [N-1:0] cmd_a,
  input  logic [N-1:0] cmd_b,
  input  logic [1:0]   cmd_opcode,
  input  logic [1:0]   cmd_fnclass,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_out,
  output logic         rsp_zerof,
  output logic         rsp_ovf,
  output logic         rsp_cout,
  output logic         rsp_err,
  output logic         ovf_sticky,
  input  logic         clr_sticky,
  output logic [15:0]  op_count
);

  state_t       state_q, state_d;
  logic [N-1:0] a_q, b_q;
  logic [1:0]   opcode_q, fnclass_q;
  logic [N-1:0] alu_out;
  logic         alu_zerof, alu_ovf, alu_cout;
  logic         accept, done;

  ALU #(.N(N)) u_alu (
    .a       (a_q),
    .b       (b_q),
    .opcode  (opcode_q),
    .fnclass (fnclass_q),
    .out     (alu_out),
    .zerof   (alu_zerof),
    .ovf     (alu_ovf),
    .c_out   (alu_cout)
  );

  // Next state and handshake outputs; reserved class skips EXEC
  always_comb begin
    state_d   = state_q;
    cmd_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    accept    = cmd_valid && (state_q == IDLE);
    done      = rsp_ready && (state_q == RESP);
    case (state_q)
      IDLE:    if (cmd_valid) state_d = (cmd_fnclass == RSVD) ? RESP : EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ALU drive registers; a reserved command leaves the previous operands in place
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      opcode_q  <= '0;
      fnclass_q <= '0;
    end else if (accept && (cmd_fnclass != RSVD)) begin
      a_q       <= cmd_a;
      b_q       <= cmd_b;
      opcode_q  <= cmd_opcode;
      fnclass_q <= cmd_fnclass;
    end
  end

  // Response registers: error response on reserved accept, ALU capture at end of EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_out   <= '0;
      rsp_zerof <= 1'b0;
      rsp_ovf   <= 1'b0;
      rsp_cout  <= 1'b0;
      rsp_err   <= 1'b0;
    end else if (accept && (cmd_fnclass == RSVD)) begin
      rsp_out   <= '0;
      rsp_zerof <= 1'b0;
      rsp_ovf   <= 1'b0;
      rsp_cout  <= 1'b0;
      rsp_err   <= 1'b1;
    end else if (state_q == EXEC) begin
      rsp_out   <= alu_out;
      rsp_zerof <= alu_zerof;
      rsp_ovf   <= alu_ovf;
      rsp_cout  <= alu_cout;
      rsp_err   <= 1'b0;
    end
  end

  // Completion bookkeeping; a set from an overflowing completion beats a clear
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count   <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      if (done) op_count <= op_count + 16'd1;
      if (done && rsp_ovf) ovf_sticky <= 1'b1;
      else if (clr_sticky) ovf_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - scoreboard bench for alu_op_sequencer
module tb_alu_op_sequencer;
  import alu_pkg::*;

  localparam int N = 32;

  logic         clk, rst;
  logic         cmd_valid, cmd_ready;
  logic [N-1:0] cmd_a, cmd_b;
  logic [1:0]   cmd_opcode, cmd_fnclass;
  logic         rsp_valid, rsp_ready;
  logic [N-1:0] rsp_out;
  logic         rsp_zerof, rsp_ovf, rsp_cout, rsp_err;
  logic         ovf_sticky, clr_sticky;
  logic [15:0]  op_count;

  typedef struct {
    logic [N-1:0] out;
    logic         zerof, ovf, cout, err;
    int           lat;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [15:0] exp_cnt = '0;
  logic        exp_sticky = 1'b0;

  alu_op_sequencer #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_opcode(cmd_opcode), .cmd_fnclass(cmd_fnclass),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_out(rsp_out), .rsp_zerof(rsp_zerof), .rsp_ovf(rsp_ovf), .rsp_cout(rsp_cout),
    .rsp_err(rsp_err), .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky), .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference results for the operations the bench issues
  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic [1:0] cls, input logic [1:0] op);
    exp_t        e;
    logic [N:0]  s;
    e.out = '0; e.ovf = 1'b0; e.cout = 1'b0; e.err = 1'b0; e.lat = 2;
    if (cls == RSVD) begin
      e.err = 1'b1;
      e.lat = 1;
    end else if (cls == ARITH && op == SUB) begin
      s = {1'b0, a} - {1'b0, b};
      e.out  = s[N-1:0];
      e.cout = (a >= b);
      e.ovf  = (a[N-1] != b[N-1]) && (e.out[N-1] != a[N-1]);
    end else if (cls == ARITH) begin
      s = {1'b0, a} + {1'b0, b};
      e.out  = s[N-1:0];
      e.cout = s[N];
      e.ovf  = (a[N-1] == b[N-1]) && (e.out[N-1] != a[N-1]);
    end else if (cls == LOGIC) begin
      e.out = a & b;
    end else begin
      e.out = a << b[4:0];
    end
    e.zerof = (cls != RSVD) && (e.out == '0);
    return e;
  endfunction

  // Issue one command, collect its response after 'hold' stalled cycles
  task automatic run_cmd(input logic [N-1:0] a, input logic [N-1:0] b, input logic [1:0] cls,
                         input logic [1:0] op, input int hold, input bit clr_done);
    exp_t e;
    int   t, w;
    exp_q.push_back(model(a, b, cls, op));
    @(negedge clk);
    cmd_a = a; cmd_b = b; cmd_fnclass = cls; cmd_opcode = op; cmd_valid = 1'b1; rsp_ready = 1'b0;
    w = 0;
    while (!cmd_ready && w < 20) begin @(negedge clk); w++; end
    t = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    w = 0;
    while (!rsp_valid && w < 20) begin @(negedge clk); w++; end
    e = exp_q.pop_front();
    total++; if (!rsp_valid || cyc - t != e.lat) begin bad++; $display("FAIL latency: got %0d valid=%b want %0d", cyc - t, rsp_valid, e.lat); end
    total++; if (rsp_out !== e.out) begin bad++; $display("FAIL rsp_out: got %h want %h", rsp_out, e.out); end
    total++; if (rsp_zerof !== e.zerof) begin bad++; $display("FAIL rsp_zerof: got %b want %b", rsp_zerof, e.zerof); end
    total++; if (rsp_ovf !== e.ovf) begin bad++; $display("FAIL rsp_ovf: got %b want %b", rsp_ovf, e.ovf); end
    total++; if (rsp_cout !== e.cout) begin bad++; $display("FAIL rsp_cout: got %b want %b", rsp_cout, e.cout); end
    total++; if (rsp_err !== e.err) begin bad++; $display("FAIL rsp_err: got %b want %b", rsp_err, e.err); end
    // Stall with a competing command presented; nothing may move
    for (int i = 0; i < hold; i++) begin
      cmd_a = 32'h9; cmd_b = 32'h1; cmd_fnclass = ARITH; cmd_opcode = ADD; cmd_valid = 1'b1;
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b1 || rsp_out !== e.out || cmd_ready !== 1'b0) begin
        bad++; $display("FAIL stall: valid=%b out=%h ready=%b want 1 %h 0", rsp_valid, rsp_out, cmd_ready, e.out);
      end
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1; clr_sticky = clr_done;
    @(negedge clk);
    rsp_ready = 1'b0; clr_sticky = 1'b0;
    exp_cnt++;
    if (e.ovf) exp_sticky = 1'b1;
    else if (clr_done) exp_sticky = 1'b0;
    total++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL post_done: valid=%b ready=%b want 0 1", rsp_valid, cmd_ready); end
    total++; if (op_count !== exp_cnt) begin bad++; $display("FAIL op_count: got %h want %h", op_count, exp_cnt); end
    total++; if (ovf_sticky !== exp_sticky) begin bad++; $display("FAIL ovf_sticky: got %b want %b", ovf_sticky, exp_sticky); end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0; clr_sticky = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_opcode = '0; cmd_fnclass = '0;
    repeat (3) @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_out !== '0 || rsp_zerof !== 1'b0 ||
        rsp_ovf !== 1'b0 || rsp_cout !== 1'b0 || rsp_err !== 1'b0 || ovf_sticky !== 1'b0 || op_count !== 16'h0) begin
      bad++;
      $display("FAIL reset_state: ready=%b valid=%b out=%h z=%b o=%b c=%b e=%b st=%b cnt=%h want 1 0 0 0 0 0 0 0 0",
               cmd_ready, rsp_valid, rsp_out, rsp_zerof, rsp_ovf, rsp_cout, rsp_err, ovf_sticky, op_count);
    end
    rst = 1'b0;
    exp_cnt = '0; exp_sticky = 1'b0;
  endtask

  task automatic test_reset_exec();
    bit seen;
    @(negedge clk);
    cmd_a = 32'd3; cmd_b = 32'd2; cmd_fnclass = ARITH; cmd_opcode = ADD; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = '0; exp_sticky = 1'b0;
    total++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_exec_ready: ready=%b valid=%b want 1 0", cmd_ready, rsp_valid); end
    seen = 1'b0;
    repeat (4) begin @(negedge clk); if (rsp_valid) seen = 1'b1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL reset_exec_rsp: got %b want 0", seen); end
    total++; if (op_count !== exp_cnt) begin bad++; $display("FAIL reset_exec_count: got %h want %h", op_count, exp_cnt); end
  endtask

  task automatic test_arith();
    run_cmd(32'd3, 32'd2, ARITH, ADD, 0, 1'b0);
    run_cmd(32'd5, 32'd5, ARITH, SUB, 0, 1'b0);
    run_cmd(32'd5, 32'd2, ARITH, SUB, 0, 1'b0);
  endtask

  task automatic test_sticky();
    run_cmd(32'h7FFF_FFFF, 32'h1, ARITH, ADD, 0, 1'b0);
    run_cmd(32'd5, 32'd3, LOGIC, AND, 0, 1'b0);
    @(negedge clk); clr_sticky = 1'b1;
    @(negedge clk); clr_sticky = 1'b0;
    exp_sticky = 1'b0;
    total++; if (ovf_sticky !== exp_sticky) begin bad++; $display("FAIL sticky_clear: got %b want %b", ovf_sticky, exp_sticky); end
    run_cmd(32'h8000_0000, 32'h8000_0000, ARITH, ADD, 0, 1'b1);
  endtask

  task automatic test_backpressure();
    run_cmd(32'd5, 32'd3, SHIFT, SHL, 5, 1'b0);
  endtask

  task automatic test_reserved();
    run_cmd(32'hDEAD_BEEF, 32'h1234, RSVD, 2'b10, 0, 1'b0);
    run_cmd(32'd0, 32'd0, ARITH, SUB, 0, 1'b0);
  endtask

  task automatic test_wrap();
    int done_n, guard;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cmd_fnclass = RSVD; cmd_opcode = 2'b00; cmd_valid = 1'b1; rsp_ready = 1'b1;
    done_n = 0; guard = 0;
    while (done_n < 65535 && guard < 200000) begin
      @(negedge clk); guard++;
      if (rsp_valid) done_n++;
    end
    cmd_valid = 1'b0;
    total++; if (guard != 2 * 65535 - 1) begin bad++; $display("FAIL err_throughput: got %0d want %0d", guard, 2 * 65535 - 1); end
    @(negedge clk);
    total++; if (op_count !== 16'hFFFF) begin bad++; $display("FAIL count_ffff: got %h want ffff", op_count); end
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    total++; if (op_count !== 16'h0000) begin bad++; $display("FAIL count_wrap: got %h want 0000", op_count); end
  endtask

  initial begin
    test_reset();
    test_reset_exec();
    test_arith();
    test_sticky();
    test_backpressure();
    test_reserved();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
